// File: rtl/keyed_hash_pkg.sv
// Shared types, widths and the per-byte absorb step used by the keyed hash block.
package keyed_hash_pkg;

  localparam int unsigned DIGEST_W = 16;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [1:0] {IDLE, ABSORB, FINAL, OUT} state_e;

  // h_next = rotl(h ^ b, rot) + key, all mod 2^DIGEST_W
  function automatic logic [DIGEST_W-1:0] hash_step(input logic [DIGEST_W-1:0] h,
                                                    input logic [BYTE_W-1:0]   b,
                                                    input logic [BYTE_W-1:0]   key,
                                                    input int unsigned         rot = 3);
    logic [DIGEST_W-1:0]   x;
    logic [2*DIGEST_W-1:0] w;
    x = h ^ {{(DIGEST_W-BYTE_W){1'b0}}, b};
    w = {x, x} << rot;
    return w[2*DIGEST_W-1 -: DIGEST_W] + {{(DIGEST_W-BYTE_W){1'b0}}, key};
  endfunction

endpackage

// File: rtl/hash_round.sv
// Purely combinational single absorb step.
module hash_round
  import keyed_hash_pkg::*;
#(
  parameter int unsigned ROT = 3
) (
  input  logic [DIGEST_W-1:0] h,
  input  logic [BYTE_W-1:0]   b,
  input  logic [BYTE_W-1:0]   key,
  output logic [DIGEST_W-1:0] h_next
);

  assign h_next = hash_step(h, b, key, ROT);

endmodule

// File: rtl/keyed_hash_absorb.sv
// Absorbs a stream of encrypted bytes and emits a 16-bit keyed digest and byte count per message.
module keyed_hash_absorb
  import keyed_hash_pkg::*;
#(
  parameter int unsigned ROT   = 3,
  parameter int unsigned LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   key,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BYTE_W-1:0]   s_data,
  input  logic                s_last,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [DIGEST_W-1:0] d_digest,
  output logic [LEN_W-1:0]    d_len
);

  state_e state_q, state_d;

  logic [DIGEST_W-1:0] h_q;
  logic [BYTE_W-1:0]   key_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DIGEST_W-1:0] digest_q;
  logic [LEN_W-1:0]    len_q;
  logic                d_valid_q;

  logic                s_fire;
  logic [DIGEST_W-1:0] round_h;
  logic [BYTE_W-1:0]   round_key;
  logic [DIGEST_W-1:0] round_out;

  assign s_fire = s_valid & s_ready;

  // First byte of a message seeds from the live key; later bytes use the latched one.
  always_comb begin
    round_h   = h_q;
    round_key = key_q;
    if (state_q == IDLE) begin
      round_h   = {key, ~key};
      round_key = key;
    end
  end

  hash_round #(
    .ROT (ROT)
  ) u_round (
    .h      (round_h),
    .b      (s_data),
    .key    (round_key),
    .h_next (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ABSORB: begin
        if (s_fire) state_d = s_last ? FINAL : ABSORB;
      end
      FINAL:   state_d = OUT;
      OUT: begin
        if (d_valid_q && d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == IDLE) || (state_q == ABSORB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      key_q     <= '0;
      cnt_q     <= '0;
      digest_q  <= '0;
      len_q     <= '0;
      d_valid_q <= 1'b0;
    end else begin
      if (s_fire) begin
        h_q <= round_out;
        if (state_q == IDLE) begin
          key_q <= key;
          cnt_q <= LEN_W'(1);
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + LEN_W'(1);
        end
      end
      if (state_q == FINAL) begin
        digest_q <= h_q ^ {key_q, key_q};
        len_q    <= cnt_q;
      end
      // d_valid rises one cycle into OUT; d_ready before that is ignored.
      if (state_q == OUT) begin
        if (!d_valid_q) begin
          d_valid_q <= 1'b1;
        end else if (d_ready) begin
          d_valid_q <= 1'b0;
        end
      end
    end
  end

  assign d_valid  = d_valid_q;
  assign d_digest = digest_q;
  assign d_len    = len_q;

endmodule

// File: tb/tb_keyed_hash_absorb.sv
// Scoreboard bench for keyed_hash_absorb: directed vectors plus a random message stream.
module tb_keyed_hash_absorb;
  import keyed_hash_pkg::*;

  localparam int unsigned ROT   = 3;
  localparam int unsigned LEN_W = 16;

  typedef struct {
    logic [15:0]      dig;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [7:0]        key;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              d_valid;
  logic              d_ready;
  logic [15:0]       d_digest;
  logic [LEN_W-1:0]  d_len;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   prod_done;

  keyed_hash_absorb #(
    .ROT   (ROT),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_digest (d_digest),
    .d_len    (d_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [7:0] k, input logic [7:0] bytes[$]);
    exp_t        r;
    logic [15:0] h;
    h = {k, ~k};
    foreach (bytes[i]) h = hash_step(h, bytes[i], k, ROT);
    r.dig = h ^ {k, k};
    r.len = (bytes.size() > 65535) ? LEN_W'(65535) : LEN_W'(bytes.size());
    return r;
  endfunction

  // Scoreboard: a digest transfers at the next rising edge when valid & ready here.
  always @(negedge clk) begin
    if (rst_n && d_valid && d_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_digest: got digest=%h len=%0d, none expected", d_digest, d_len);
      end else begin
        e = sb.pop_front();
        total++;
        if (d_digest !== e.dig) begin
          bad++;
          $display("FAIL sb_digest: got %h expected %h", d_digest, e.dig);
        end
        total++;
        if (d_len !== e.len) begin
          bad++;
          $display("FAIL sb_len: got %0d expected %0d", d_len, e.len);
        end
      end
    end
  end

  // Drives one message byte by byte, holding each byte until accepted.
  task automatic send_msg(input logic [7:0] k, input logic [7:0] bytes[$], input bit chg_key,
                          input int max_gap);
    sb.push_back(model(k, bytes));
    for (int i = 0; i < bytes.size(); i++) begin
      int n;
      bit rdy;
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = bytes[i];
      s_last  = (i == bytes.size() - 1);
      key     = (i == 0 || !chg_key) ? k : 8'hFF;
      n = 0;
      do begin
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!rdy && n < 2000);
      if (!rdy) begin
        total++;
        bad++;
        $display("FAIL send_timeout: s_ready=0 expected 1 within 2000 cycles");
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!d_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!d_valid) begin
      total++;
      bad++;
      $display("FAIL %s_valid_timeout: d_valid=0 expected 1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || d_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || d_valid) begin
      total++;
      bad++;
      $display("FAIL %s_drain: pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key     = 8'h00;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_d_valid: got %b expected 0", d_valid); end
    total++; if (d_digest !== 16'h0) begin bad++; $display("FAIL rst_digest: got %h expected 0000", d_digest); end
    total++; if (d_len !== '0) begin bad++; $display("FAIL rst_len: got %0d expected 0", d_len); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    exp_t e;
    e.dig = 16'h07F8;
    e.len = LEN_W'(1);
    sb.push_back(e);
    key = 8'h00; s_data = 8'h00; s_last = 1'b1; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL single_valid_n0: got %b expected 0", d_valid); end
    @(posedge clk);
    #1;
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL single_valid_n1: got %b expected 0", d_valid); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL single_ready_n1: got %b expected 0", s_ready); end
    @(posedge clk);
    #1;
    total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL single_valid_n2: got %b expected 1", d_valid); end
    total++; if (d_digest !== 16'h07F8) begin bad++; $display("FAIL single_digest: got %h expected 07F8", d_digest); end
    total++; if (d_len !== LEN_W'(1)) begin bad++; $display("FAIL single_len: got %0d expected 1", d_len); end
    @(posedge clk);
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready_n3: got %b expected 1", s_ready); end
    wait_drain("single");
  endtask

  task automatic test_two_bytes(input bit chg_key, input string name);
    logic [7:0] m[$];
    m = '{8'h6C, 8'h9D};
    d_ready = 1'b1;
    send_msg(8'h3C, m, chg_key, 0);
    wait_valid(name);
    total++;
    if (d_digest !== 16'h15BF) begin
      bad++;
      $display("FAIL %s_digest: got %h expected 15BF", name, d_digest);
    end
    wait_drain(name);
  endtask

  task automatic test_hold();
    logic [7:0] m[$];
    logic [7:0] one[$];
    int         n;
    bit         rdy;
    m = '{8'h6C, 8'h9D};
    one = '{8'hAA};
    d_ready = 1'b0;
    send_msg(8'h3C, m, 1'b0, 0);
    wait_valid("hold");
    sb.push_back(model(8'h00, one));
    @(posedge clk);
    #1;
    key = 8'h00; s_data = 8'hAA; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b expected 1", d_valid); end
      total++; if (d_digest !== 16'h15BF) begin bad++; $display("FAIL hold_digest: got %h expected 15BF", d_digest); end
      total++; if (d_len !== LEN_W'(2)) begin bad++; $display("FAIL hold_len: got %0d expected 2", d_len); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL hold_ready: got %b expected 0", s_ready); end
    end
    d_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    s_valid = 1'b0; s_last = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL hold_release: s_ready=0 expected 1");
    end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid();
    logic [7:0] one[$];
    one = '{8'h00};
    d_ready = 1'b1;
    key = 8'h3C; s_data = 8'h6C; s_last = 1'b0; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (d_len !== '0) begin bad++; $display("FAIL rstmid_len: got %0d expected 0", d_len); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b expected 1", s_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got d_valid=%b expected 0", d_valid); end
    end
    send_msg(8'h00, one, 1'b0, 0);
    wait_valid("rstmid");
    total++;
    if (d_digest !== 16'h07F8) begin
      bad++;
      $display("FAIL rstmid_digest: got %h expected 07F8", d_digest);
    end
    wait_drain("rstmid");
  endtask

  task automatic test_random();
    prod_done = 1'b0;
    fork
      begin
        for (int m = 0; m < 12; m++) begin
          logic [7:0] msg[$];
          int         len;
          len = (m == 0) ? 300 : $urandom_range(1, 300);
          for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
          send_msg(8'($urandom_range(0, 255)), msg, $urandom_range(0, 1) == 1, 2);
        end
        prod_done = 1'b1;
      end
      begin
        int n = 0;
        while ((!prod_done || sb.size() != 0) && n < 60000) begin
          @(posedge clk);
          #1;
          d_ready = ($urandom_range(0, 3) != 0);
          n++;
        end
        d_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_bytes(1'b0, "two_bytes");
    test_two_bytes(1'b1, "key_change");
    test_hold();
    test_reset_mid();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
